// File: rtl/round_scorer.sv
// Two-player round scorer: detects end-of-field presses, tracks round wins and decides the match.
// Define ROUND_SCORER_HEX_EN to build the 7-segment score decoders; otherwise hexL/hexR stay blank.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   S_PLAY      | ball in flight, end presses are scored
//   S_ROUND_END | one-cycle pause after a point, inputs ignored, nextRound high
//   S_GAME_OVER | match decided, everything frozen until reset

module round_scorer #(
   parameter int unsigned WIN_SCORE = 7
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       L,
   input  logic       R,
   input  logic       leftEnd,
   input  logic       rightEnd,
   output logic       nextRound,
   output logic [2:0] leftScore,
   output logic [2:0] rightScore,
   output logic       gameOver,
   output logic       leftWins,
   output logic [6:0] hexL,
   output logic [6:0] hexR
);

   typedef enum logic [1:0] {
      S_PLAY      = 2'd0,
      S_ROUND_END = 2'd1,
      S_GAME_OVER = 2'd2
   } state_t;

   localparam logic [2:0] LP_WIN = 3'(WIN_SCORE);

   state_t     r_state;
   logic [2:0] r_left_score;
   logic [2:0] r_right_score;
   logic       r_next_round;
   logic       r_game_over;
   logic       r_left_wins;

   logic       w_in_play;
   logic       w_left_pt;
   logic       w_right_pt;
   logic [2:0] w_left_inc;
   logic [2:0] w_right_inc;

   // Simultaneous presses cancel; a press at the opposite end is a miss.
   assign w_in_play   = (r_state == S_PLAY);
   assign w_left_pt   = w_in_play & leftEnd  & L & ~R;
   assign w_right_pt  = w_in_play & rightEnd & R & ~L;
   assign w_left_inc  = r_left_score  + 3'd1;
   assign w_right_inc = r_right_score + 3'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_PLAY;
         r_left_score  <= 3'd0;
         r_right_score <= 3'd0;
         r_next_round  <= 1'b0;
         r_game_over   <= 1'b0;
         r_left_wins   <= 1'b0;
      end else begin
         r_next_round <= 1'b0;
         case (r_state)
            S_PLAY: begin
               if (w_left_pt) begin
                  r_left_score <= w_left_inc;
                  if (w_left_inc >= LP_WIN) begin
                     r_state     <= S_GAME_OVER;
                     r_game_over <= 1'b1;
                     r_left_wins <= 1'b1;
                  end else begin
                     r_state      <= S_ROUND_END;
                     r_next_round <= 1'b1;
                  end
               end else if (w_right_pt) begin
                  r_right_score <= w_right_inc;
                  if (w_right_inc >= LP_WIN) begin
                     r_state     <= S_GAME_OVER;
                     r_game_over <= 1'b1;
                     r_left_wins <= 1'b0;
                  end else begin
                     r_state      <= S_ROUND_END;
                     r_next_round <= 1'b1;
                  end
               end
            end
            S_ROUND_END: r_state <= S_PLAY;
            S_GAME_OVER: r_state <= S_GAME_OVER;
            default:     r_state <= S_PLAY;
         endcase
      end
   end

   assign nextRound  = r_next_round;
   assign leftScore  = r_left_score;
   assign rightScore = r_right_score;
   assign gameOver   = r_game_over;
   assign leftWins   = r_left_wins;

`ifdef ROUND_SCORER_HEX_EN
   // Active-low segments, bit order gfedcba.
   function automatic logic [6:0] seg_decode(input logic [2:0] digit);
      logic [6:0] seg;
      seg = 7'b1111111;
      case (digit)
         3'd0: seg = 7'b1000000;
         3'd1: seg = 7'b1111001;
         3'd2: seg = 7'b0100100;
         3'd3: seg = 7'b0110000;
         3'd4: seg = 7'b0011001;
         3'd5: seg = 7'b0010010;
         3'd6: seg = 7'b0000010;
         3'd7: seg = 7'b1111000;
         default: seg = 7'b1111111;
      endcase
      return seg;
   endfunction

   assign hexL = seg_decode(r_left_score);
   assign hexR = seg_decode(r_right_score);
`else
   assign hexL = 7'b1111111;
   assign hexR = 7'b1111111;
`endif

endmodule
